cpu_core: RTL and testbench

- Small 16-bit multi-cycle accumulator-free register CPU: 16 x 16-bit general registers, 6-bit PC, Harvard memory (64-word instruction ROM, 64-word data RAM).
- Fetches one 16-bit instruction per pass from an external combinational ROM and executes it.
- Drives an external RAM for LOAD/STORE.
- Top-level processing element of the system, between the ROM and RAM blocks.

---
 rtl/cpu_core.sv | 167 ++++++++++++++++
 tb/tb_cpu_core.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: 16-bit multi-cycle register CPU with 16 GPRs and a 6-bit PC.
// Fetches from a combinational ROM and drives a registered-read data RAM.
module cpu_core (
    input  logic        clk_main,
    input  logic        reset,
    input  logic [15:0] data_from_rom,
    output logic [5:0]  address_to_rom,
    output logic        enable_to_rom,
    input  logic [15:0] data_from_ram,
    output logic        write_enable_to_ram,
    output logic        read_enable_to_ram,
    output logic [5:0]  address_to_ram,
    output logic [15:0] data_to_ram,
    output logic        enable_ram_read
);

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_BEQZ  = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_e      state_q;
    logic [5:0]  pc_q;
    logic [15:0] ir_q;
    logic [15:0] rf_q [16];

    logic [3:0]  op, rd, rs, rt;
    logic [5:0]  addr6;
    logic [3:0]  f_op, f_rd;
    logic [5:0]  f_addr;
    logic [15:0] a, b, alu_d;
    logic [5:0]  pc_inc;
    logic        is_alu, is_load, is_halt, is_jump;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign rs     = ir_q[7:4];
    assign rt     = ir_q[3:0];
    assign addr6  = ir_q[5:0];
    assign f_op   = data_from_rom[15:12];
    assign f_rd   = data_from_rom[11:8];
    assign f_addr = data_from_rom[5:0];

    assign a      = rf_q[rs];
    assign b      = rf_q[rt];
    assign pc_inc = pc_q + 6'd1;

    // PC is forced to 0 by reset, so this also reads 0 while in INIT
    assign address_to_rom = pc_q;

    assign is_alu  = (op <= OP_LDI);
    assign is_load = (op == OP_LOAD);
    assign is_halt = (op == OP_HALT);
    assign is_jump = (op == OP_JMP) ||
                     ((op == OP_BEQZ) && (rf_q[rd] == 16'h0000));

    always_comb begin
        alu_d = '0;
        unique case (op)
            OP_ADD:  alu_d = a + b;
            OP_SUB:  alu_d = a - b;
            OP_AND:  alu_d = a & b;
            OP_OR:   alu_d = a | b;
            OP_XOR:  alu_d = a ^ b;
            OP_NOT:  alu_d = ~a;
            OP_SHL:  alu_d = a << b[3:0];
            OP_SHR:  alu_d = a >> b[3:0];
            OP_LDI:  alu_d = {8'h00, ir_q[7:0]};
            default: alu_d = '0;
        endcase
    end

    // Outputs are registered: each state sets up the bus for the next one
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q             <= S_INIT;
            pc_q                <= '0;
            ir_q                <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
            enable_to_rom       <= 1'b0;
            write_enable_to_ram <= 1'b0;
            read_enable_to_ram  <= 1'b0;
            address_to_ram      <= '0;
            data_to_ram         <= '0;
            enable_ram_read     <= 1'b0;
        end else begin
            enable_to_rom       <= 1'b0;
            write_enable_to_ram <= 1'b0;
            read_enable_to_ram  <= 1'b0;
            address_to_ram      <= '0;
            data_to_ram         <= '0;
            enable_ram_read     <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    state_q       <= S_FETCH;
                    enable_to_rom <= 1'b1;
                end
                S_FETCH: begin
                    ir_q    <= data_from_rom;
                    state_q <= S_EXEC;
                    if (f_op == OP_STORE) begin
                        write_enable_to_ram <= 1'b1;
                        address_to_ram      <= f_addr;
                        data_to_ram         <= rf_q[f_rd];
                    end else if (f_op == OP_LOAD) begin
                        read_enable_to_ram <= 1'b1;
                        address_to_ram     <= f_addr;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_load: begin
                            state_q         <= S_WB;
                            enable_ram_read <= 1'b1;
                            address_to_ram  <= addr6;
                        end
                        is_halt: begin
                            state_q <= S_HALT;
                        end
                        is_jump: begin
                            state_q       <= S_FETCH;
                            enable_to_rom <= 1'b1;
                            pc_q          <= addr6;
                        end
                        default: begin
                            state_q       <= S_FETCH;
                            enable_to_rom <= 1'b1;
                            pc_q          <= pc_inc;
                            if (is_alu) rf_q[rd] <= alu_d;
                        end
                    endcase
                end
                S_WB: begin
                    rf_q[rd]      <= data_from_ram;
                    pc_q          <= pc_inc;
                    state_q       <= S_FETCH;
                    enable_to_rom <= 1'b1;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: ISA-level reference model feeding fetch/store/load scoreboards.
// Directed programs plus randomized programs drive the core through ROM/RAM models.
module tb_cpu_core;

    logic        clk_main = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_from_rom;
    logic [5:0]  address_to_rom;
    logic        enable_to_rom;
    logic [15:0] data_from_ram = '0;
    logic        write_enable_to_ram;
    logic        read_enable_to_ram;
    logic [5:0]  address_to_ram;
    logic [15:0] data_to_ram;
    logic        enable_ram_read;

    cpu_core dut (
        .clk_main            (clk_main),
        .reset               (reset),
        .data_from_rom       (data_from_rom),
        .address_to_rom      (address_to_rom),
        .enable_to_rom       (enable_to_rom),
        .data_from_ram       (data_from_ram),
        .write_enable_to_ram (write_enable_to_ram),
        .read_enable_to_ram  (read_enable_to_ram),
        .address_to_ram      (address_to_ram),
        .data_to_ram         (data_to_ram),
        .enable_ram_read     (enable_ram_read)
    );

    always #5 clk_main = ~clk_main;

    logic [15:0] rom [64];
    logic [15:0] ram [64];
    logic [15:0] ram_init [64];
    logic        ram_load = 1'b0;

    assign data_from_rom = rom[address_to_rom];

    always @(posedge clk_main) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
        end else begin
            if (read_enable_to_ram) data_from_ram <= ram[address_to_ram];
            if (write_enable_to_ram) ram[address_to_ram] <= data_to_ram;
        end
    end

    int          fq [$];
    logic [21:0] sq [$];
    int          lq [$];
    int          flog_a [$];
    int          flog_c [$];
    logic [21:0] slog [$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    bit          prev_re = 1'b0;
    int          prev_addr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT shows a fetch or RAM access
    always @(negedge clk_main) begin
        cyc++;
        if (mon_en) begin
            if (enable_to_rom) begin
                flog_a.push_back(int'(address_to_rom));
                flog_c.push_back(cyc);
                if (fq.size() == 0) fail("fetch_unexpected");
                else chk("fetch_addr", address_to_rom, fq.pop_front());
            end
            if (write_enable_to_ram) begin
                slog.push_back({address_to_ram, data_to_ram});
                if (sq.size() == 0) fail("store_unexpected");
                else begin
                    logic [21:0] e;
                    e = sq.pop_front();
                    chk("store_addr", address_to_ram, int'(e[21:16]));
                    chk("store_data", data_to_ram, int'(e[15:0]));
                end
            end
            if (read_enable_to_ram) begin
                if (lq.size() == 0) fail("load_unexpected");
                else chk("load_addr", address_to_ram, lq.pop_front());
            end
            if (enable_ram_read) begin
                chk("wb_after_read", int'(prev_re), 1);
                chk("wb_addr_held", address_to_ram, prev_addr);
            end
            if ($countones({enable_to_rom, write_enable_to_ram,
                            read_enable_to_ram, enable_ram_read}) != 0)
                chk("strobe_onehot", $countones({enable_to_rom,
                    write_enable_to_ram, read_enable_to_ram,
                    enable_ram_read}), 1);
            if (!write_enable_to_ram && !read_enable_to_ram && !enable_ram_read)
                chk("ram_addr_idle", address_to_ram, 0);
            if (!write_enable_to_ram)
                chk("ram_data_idle", data_to_ram, 0);
        end
        prev_re = read_enable_to_ram;
        prev_addr = int'(address_to_ram);
    end

    // Instruction-level interpreter: one loop pass per instruction
    task automatic run_model(input int max_steps, output int cycles,
                             output bit halted);
        int r [16];
        int m [64];
        int pc;
        for (int i = 0; i < 16; i++) r[i] = 0;
        for (int i = 0; i < 64; i++) m[i] = int'(ram_init[i]);
        pc = 0;
        cycles = 0;
        halted = 1'b0;
        for (int s = 0; s < max_steps && !halted; s++) begin
            logic [15:0] ins;
            int op, d, a, b, ad, nxt;
            ins = rom[pc];
            op = int'(ins[15:12]);
            d = int'(ins[11:8]);
            a = r[ins[7:4]];
            b = r[ins[3:0]];
            ad = int'(ins[5:0]);
            fq.push_back(pc);
            cycles += 2;
            nxt = (pc + 1) % 64;
            case (op)
                0: r[d] = (a + b) % 65536;
                1: r[d] = (a - b + 65536) % 65536;
                2: r[d] = a & b;
                3: r[d] = a | b;
                4: r[d] = a ^ b;
                5: r[d] = 65535 - a;
                6: r[d] = (a * (1 << (b % 16))) % 65536;
                7: r[d] = a / (1 << (b % 16));
                8: r[d] = int'(ins[7:0]);
                9: begin
                    lq.push_back(ad);
                    r[d] = m[ad];
                    cycles += 1;
                end
                10: begin
                    sq.push_back({6'(ad), 16'(r[d])});
                    m[ad] = r[d];
                end
                11: nxt = ad;
                12: if (r[d] == 0) nxt = ad;
                15: begin
                    halted = 1'b1;
                    nxt = pc;
                end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    task automatic start_prog(input int max_steps);
        int  c;
        bit  h;
        fq.delete();
        sq.delete();
        lq.delete();
        flog_a.delete();
        flog_c.delete();
        slog.delete();
        run_model(max_steps, c, h);
        reset = 1'b1;
        ram_load = 1'b1;
        @(posedge clk_main);
        #1 ram_load = 1'b0;
        @(posedge clk_main);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_main);
        chk("init_rom_addr", address_to_rom, 0);
        chk("init_strobes", {enable_to_rom, write_enable_to_ram,
            read_enable_to_ram, enable_ram_read}, 0);
        chk("init_ram_bus", {address_to_ram, data_to_ram}, 0);
        @(negedge clk_main);
        chk("first_fetch_en", enable_to_rom, 1);
        chk("first_fetch_addr", address_to_rom, 0);
        repeat (c + (h ? 8 : 0)) @(posedge clk_main);
        #1 mon_en = 1'b0;
        chk("fetch_q_left", fq.size(), 0);
        chk("store_q_left", sq.size(), 0);
        chk("load_q_left", lq.size(), 0);
    endtask

    function automatic int next_after(input int a);
        for (int i = 0; i + 1 < flog_a.size(); i++)
            if (flog_a[i] == a) return flog_a[i + 1];
        return -1;
    endfunction

    function automatic int gap_after(input int a);
        for (int i = 0; i + 1 < flog_a.size(); i++)
            if (flog_a[i] == a) return flog_c[i + 1] - flog_c[i];
        return -1;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            rom[i] = 16'hF000;
            ram_init[i] = 16'($urandom);
        end
    endtask

    initial begin
        bit seen;

        // Basic program ending in HALT
        clear_mem();
        rom[0] = 16'h8006;
        rom[1] = 16'h8211;
        rom[2] = 16'h0320;
        rom[3] = 16'h8103;
        rom[4] = 16'hA013;
        rom[5] = 16'hFF00;
        start_prog(20);
        if (slog.size() >= 1) chk("p1_store", int'(slog[0]), {6'd19, 16'd6});
        else fail("p1_store_missing");
        repeat (4) begin
            @(negedge clk_main);
            chk("halt_pc", address_to_rom, 5);
            chk("halt_strobes", {enable_to_rom, write_enable_to_ram,
                read_enable_to_ram, enable_ram_read}, 0);
        end

        // ALU, LOAD, branches, wrap (restarts from HALT via reset)
        clear_mem();
        rom[0]  = 16'h84F0;
        rom[1]  = 16'h8504;
        rom[2]  = 16'h6645;
        rom[3]  = 16'h1754;
        rom[4]  = 16'hA600;
        rom[5]  = 16'hA701;
        rom[6]  = 16'h982A;
        rom[7]  = 16'hA802;
        rom[8]  = 16'hC90A;
        rom[10] = 16'h8901;
        rom[11] = 16'hC914;
        rom[12] = 16'hB03F;
        rom[63] = 16'hD000;
        ram_init[42] = 16'h1234;
        start_prog(40);
        if (slog.size() >= 3) begin
            chk("shl_store", int'(slog[0]), {6'd0, 16'h0F00});
            chk("sub_store", int'(slog[1]), {6'd1, 16'hFF14});
            chk("load_store", int'(slog[2]), {6'd2, 16'h1234});
        end else fail("p2_stores_missing");
        chk("beqz_taken", next_after(8), 10);
        chk("beqz_not_taken", next_after(11), 12);
        chk("jmp_63", next_after(12), 63);
        chk("pc_wrap", next_after(63), 0);
        chk("load_cycles", gap_after(6), 3);
        chk("ldi_cycles", gap_after(0), 2);

        // Reset during the WB cycle of a LOAD
        clear_mem();
        rom[0] = 16'h9105;
        rom[1] = 16'hA106;
        ram_init[5] = 16'hBEEF;
        reset = 1'b1;
        ram_load = 1'b1;
        @(posedge clk_main);
        #1 ram_load = 1'b0;
        @(posedge clk_main);
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_main);
            if (enable_ram_read) seen = 1'b1;
        end
        if (!seen) fail("wb_timeout");
        reset = 1'b1;
        @(negedge clk_main);
        chk("rst_wb_strobes", {enable_to_rom, write_enable_to_ram,
            read_enable_to_ram, enable_ram_read}, 0);
        chk("rst_wb_bus", {address_to_ram, data_to_ram}, 0);
        chk("rst_wb_pc", address_to_rom, 0);
        rom[0] = 16'hA107;
        rom[1] = 16'hF000;
        start_prog(10);
        if (slog.size() >= 1) chk("rst_wb_reg", int'(slog[0]), {6'd7, 16'd0});
        else fail("rst_wb_store_missing");

        // Randomized programs; tail stores dump every register
        for (int t = 0; t < 15; t++) begin
            clear_mem();
            for (int i = 0; i < 47; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h8;
                rom[i] = {op, 12'($urandom)};
            end
            for (int i = 0; i < 16; i++)
                rom[47 + i] = {4'hA, 4'(i), 2'b00, 6'(32 + i)};
            rom[63] = 16'hF000;
            start_prog(150);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
